// File: rtl/sftm_pkg.sv
// Shared constants and types for the SFTM patch streamer.
// Contents: stride constants, patch geometry, output FIFO depth, FSM state
// enum and the issue-pipeline slot payload.
package sftm_pkg;

    localparam int unsigned STRIDE_CONV   = 2;
    localparam int unsigned STRIDE_DECONV = 4;
    localparam int unsigned PATCH_DIM     = 4;
    localparam int unsigned PATCH_ELEMS   = 16;
    localparam int unsigned FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        SFTM_IDLE  = 2'd0,
        SFTM_ISSUE = 2'd1,
        SFTM_DRAIN = 2'd2
    } sftm_state_e;

    // One element slot travelling from issue to the FIFO push.
    typedef struct packed {
        logic valid;   // slot carries an element
        logic rd;      // element was read from memory (else zero-filled)
    } sftm_slot_t;

endpackage

// File: rtl/sftm_patch_streamer_if.sv
// Patch stream towards SFTM's input port.
// master (streamer): drives sftm_start, patch_data, patch_valid, patch_last;
//                    receives hold.
// slave  (SFTM):     the reverse.
interface sftm_patch_streamer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              sftm_start;
    logic [DATA_W-1:0] patch_data;
    logic              patch_valid;
    logic              patch_last;
    logic              hold;

    modport master (
        output sftm_start,
        output patch_data,
        output patch_valid,
        output patch_last,
        input  hold
    );

    modport slave (
        input  sftm_start,
        input  patch_data,
        input  patch_valid,
        input  patch_last,
        output hold
    );
endinterface

// File: rtl/sftm_stream_fifo.sv
// Small circular FIFO holding serialised samples ahead of the stream output.
// Ports: clk, rst_n (async, active-low), i_push/i_data, i_pop, o_data (head),
//        o_count (occupancy), o_empty.
// Pop on empty is ignored; push on full is accepted only alongside a pop.
module sftm_stream_fifo #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sftm_patch_streamer.sv
// Walks a feature map in a synchronous-read buffer, cuts it into overlapping
// 4x4 patches (stride 2 conv / 4 deconv) and serialises each patch row-major
// onto a one-sample-per-cycle stream for SFTM.
// Ports: clk, rst_n (async, active-low); start/conv_mode/fm_base/fm_width/
//        fm_height (pass setup, latched at start); mem_rd_en/mem_addr/
//        mem_rd_data (1-cycle read latency buffer); busy, done; strm (patch
//        stream master: sftm_start, patch_data, patch_valid, patch_last, hold).
// Build option: SFTM_STREAMER_BORDER_CLAMP_EN replicates edge elements for
// out-of-bounds coordinates; otherwise they are zero-filled without a read.
// patch_valid/patch_last respond to hold in the same cycle, so they are a
// decode of registered FIFO state gated by hold.
module sftm_patch_streamer
    import sftm_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DIM_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  conv_mode,
    input  logic [ADDR_W-1:0]     fm_base,
    input  logic [DIM_W-1:0]      fm_width,
    input  logic [DIM_W-1:0]      fm_height,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  busy,
    output logic                  done,
    sftm_patch_streamer_if.master strm
);

    localparam int unsigned CW    = DIM_W + 1;              // coordinate width, room for origin+3
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRW   = CNT_W + 1;              // credit sum width
    localparam logic [1:0]  IDX_MAX  = 2'(PATCH_DIM - 1);
    localparam logic [3:0]  LAST_CNT = 4'(PATCH_ELEMS - 1);

    localparam logic [1:0] ST_IDLE  = 2'(SFTM_IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(SFTM_ISSUE);
    localparam logic [1:0] ST_DRAIN = 2'(SFTM_DRAIN);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_load;
    logic              w_issue;
    logic              w_done_nxt;

    logic [CW-1:0]     r_stride;
    logic [DIM_W-1:0]  r_w;
    logic [DIM_W-1:0]  r_h;
    logic [ADDR_W-1:0] r_wa;          // width as address increment (one row)
    logic [ADDR_W-1:0] r_sw;          // stride * width (one origin row)
    logic [CW-1:0]     r_r0;
    logic [CW-1:0]     r_c0;
    logic [1:0]        r_i;
    logic [1:0]        r_j;
    logic [ADDR_W-1:0] r_row_base;    // base + clamped(r0+i)*width
    logic [ADDR_W-1:0] r_orow_base;   // base + r0*width
    sftm_slot_t        r_s1;          // slot in the mem_rd_en cycle
    sftm_slot_t        r_s2;          // slot in the read-data cycle
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_done;
    logic [3:0]        r_emit_cnt;

    logic [CW-1:0]     w_r;
    logic [CW-1:0]     w_c;
    logic [CW-1:0]     w_w_ext;
    logic [CW-1:0]     w_h_ext;
    logic [CW-1:0]     w_c_eff;
    logic              w_rd_elem;
    logic [ADDR_W-1:0] w_elem_addr;
    logic [CW-1:0]     w_c0_nx;
    logic [CW-1:0]     w_r0_nx;
    logic              w_col_wrap;
    logic              w_last_elem;
    logic              w_row_nx_in;
    logic              w_credit;
    logic              w_dims_ok;
    logic              w_drained;

    logic [DATA_W-1:0] w_fifo_head;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;

    // Current element coordinates and border handling.
    assign w_r     = r_r0 + CW'(r_i);
    assign w_c     = r_c0 + CW'(r_j);
    assign w_w_ext = CW'(r_w);
    assign w_h_ext = CW'(r_h);

`ifdef SFTM_STREAMER_BORDER_CLAMP_EN
    assign w_c_eff   = (w_c >= w_w_ext) ? (w_w_ext - CW'(1)) : w_c;
    assign w_rd_elem = 1'b1;
`else
    logic w_oob;
    assign w_oob     = (w_r >= w_h_ext) || (w_c >= w_w_ext);
    assign w_c_eff   = w_c;
    assign w_rd_elem = !w_oob;
`endif

    assign w_elem_addr = r_row_base + ADDR_W'(w_c_eff);

    // Walk bookkeeping: next origin, last element, next row still in map.
    assign w_c0_nx     = r_c0 + r_stride;
    assign w_r0_nx     = r_r0 + r_stride;
    assign w_col_wrap  = (w_c0_nx >= w_w_ext);
    assign w_last_elem = (r_i == IDX_MAX) && (r_j == IDX_MAX) && w_col_wrap && (w_r0_nx >= w_h_ext);
    assign w_row_nx_in = ((w_r + CW'(1)) < w_h_ext);

    // Credit counts FIFO entries plus slots still travelling to it.
    assign w_credit  = (CRW'(w_fifo_count) + CRW'(r_s1.valid) + CRW'(r_s2.valid)) < CRW'(FIFO_DEPTH);
    assign w_dims_ok = (fm_width != '0) && (fm_height != '0);
    assign w_drained = !r_s1.valid && !r_s2.valid &&
                       ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_dims_ok) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_last_elem) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pass setup, element walk and issue pipeline. Element 0 is issued on
    // the start edge straight from the inputs; the walk then points at (0,1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride    <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_wa        <= '0;
            r_sw        <= '0;
            r_r0        <= '0;
            r_c0        <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_row_base  <= '0;
            r_orow_base <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_done      <= 1'b0;
            r_emit_cnt  <= '0;
        end else begin
            r_done      <= w_done_nxt;
            r_s2        <= r_s1;
            r_mem_rd_en <= 1'b0;
            if (w_pop) r_emit_cnt <= r_emit_cnt + 4'd1;

            if (w_load) begin
                r_stride    <= conv_mode ? CW'(STRIDE_CONV) : CW'(STRIDE_DECONV);
                r_w         <= fm_width;
                r_h         <= fm_height;
                r_wa        <= ADDR_W'(fm_width);
                r_sw        <= conv_mode ? (ADDR_W'(fm_width) << 1) : (ADDR_W'(fm_width) << 2);
                r_r0        <= '0;
                r_c0        <= '0;
                r_i         <= '0;
                r_j         <= 2'd1;
                r_row_base  <= fm_base;
                r_orow_base <= fm_base;
                r_s1        <= '{valid: 1'b1, rd: 1'b1};
                r_mem_rd_en <= 1'b1;
                r_mem_addr  <= fm_base;
            end else if (w_issue) begin
                r_s1        <= '{valid: 1'b1, rd: w_rd_elem};
                r_mem_rd_en <= w_rd_elem;
                if (w_rd_elem) r_mem_addr <= w_elem_addr;

                if (r_j != IDX_MAX) begin
                    r_j <= r_j + 2'd1;
                end else begin
                    r_j <= '0;
                    if (r_i != IDX_MAX) begin
                        r_i <= r_i + 2'd1;
                        // Rows past the bottom keep the last row's base (clamp).
                        if (w_row_nx_in) r_row_base <= r_row_base + r_wa;
                    end else begin
                        r_i <= '0;
                        if (w_col_wrap) begin
                            r_c0        <= '0;
                            r_r0        <= w_r0_nx;
                            r_orow_base <= r_orow_base + r_sw;
                            r_row_base  <= r_orow_base + r_sw;
                        end else begin
                            r_c0        <= w_c0_nx;
                            r_row_base  <= r_orow_base;
                        end
                    end
                end
            end else begin
                r_s1 <= '0;
            end
        end
    end

    // Read data or a zero-filled slot enters the FIFO in issue order.
    assign w_push      = r_s2.valid;
    assign w_push_data = r_s2.rd ? mem_rd_data : '0;
    assign w_pop       = !strm.hold && !w_fifo_empty;

    sftm_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign mem_rd_en        = r_mem_rd_en;
    assign mem_addr         = r_mem_addr;
    assign busy             = (r_state != ST_IDLE);
    assign done             = r_done;
    assign strm.sftm_start  = (r_state != ST_IDLE);
    assign strm.patch_data  = w_fifo_head;
    assign strm.patch_valid = w_pop;
    assign strm.patch_last  = w_pop && (r_emit_cnt == LAST_CNT);

endmodule

// File: tb/tb_sftm_patch_streamer.sv
// Self-checking bench for sftm_patch_streamer: randomized passes compared
// against a loop-nest model of the patch walk and a ramp-style memory.
module tb_sftm_patch_streamer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DIM_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              conv_mode;
    logic [ADDR_W-1:0] fm_base;
    logic [DIM_W-1:0]  fm_width;
    logic [DIM_W-1:0]  fm_height;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              busy;
    logic              done;
    logic [15:0]       key;

    sftm_patch_streamer_if #(.DATA_W(DATA_W)) u_if ();

    sftm_patch_streamer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .conv_mode   (conv_mode),
        .fm_base     (fm_base),
        .fm_width    (fm_width),
        .fm_height   (fm_height),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done),
        .strm        (u_if)
    );

    always #5 clk = ~clk;

    // Buffer model: data = address ^ key one cycle after a read, noise otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr ^ key;
        else           mem_rd_data <= 16'($urandom);
    end

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    logic [15:0] exp_data[$];
    logic [15:0] exp_addr[$];
    int          exp_idx[$];
    logic [15:0] got_q[$];

    // Expected stream: origins on the stride grid, 4x4 row-major inside.
    function automatic void build_model(input bit conv, input logic [15:0] base, input int w, input int h);
        int s = conv ? 2 : 4;
        int k = 0;
        exp_data.delete(); exp_addr.delete(); exp_idx.delete();
        for (int r0 = 0; r0 < h; r0 += s)
            for (int c0 = 0; c0 < w; c0 += s)
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        int r = r0 + i;
                        int c = c0 + j;
                        logic [15:0] a;
`ifdef SFTM_STREAMER_BORDER_CLAMP_EN
                        if (r >= h) r = h - 1;
                        if (c >= w) c = w - 1;
                        a = 16'(int'(base) + r * w + c);
                        exp_addr.push_back(a); exp_idx.push_back(k); exp_data.push_back(a ^ key);
`else
                        if (r >= h || c >= w) exp_data.push_back(16'h0);
                        else begin
                            a = 16'(int'(base) + r * w + c);
                            exp_addr.push_back(a); exp_idx.push_back(k); exp_data.push_back(a ^ key);
                        end
`endif
                        k++;
                    end
    endfunction

    function automatic logic [15:0] got_at(input int idx);
        return (idx < got_q.size()) ? got_q[idx] : 16'hDEAD;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {26'd0, mem_rd_en, u_if.sftm_start, u_if.patch_valid, u_if.patch_last, busy, done}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_data"}, u_if.patch_data, 32'd0);
    endtask

    // One pass; abort_at>0 asserts reset right after that many samples.
    task automatic run_pass(input bit conv, input logic [15:0] base, input int w, input int h,
                            input bit hold_rand, input int abort_at, input string nm);
        int nrd = 0, nval = 0, done_cyc = -1, first_rd = -1, first_val = -1, last_val = -1;
        int np;
        bit prot_ok = 1, credit_ok = 1, post_ok = 1;
        build_model(conv, base, w, h);
        np = exp_data.size() / 16;
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1; conv_mode = conv; fm_base = base;
        fm_width = 10'(w); fm_height = 10'(h); u_if.hold = 1'b0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            u_if.hold = hold_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (cyc == 1) check({nm, "_busy1"}, {busy, u_if.sftm_start}, (np > 0) ? 32'd3 : 32'd0);
            if (u_if.patch_valid && u_if.hold) prot_ok = 0;
            if (mem_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (nrd < exp_addr.size()) begin
                    check({nm, "_addr"}, mem_addr, exp_addr[nrd]);
                    if (exp_idx[nrd] - nval > 3) credit_ok = 0;
                end else prot_ok = 0;
                nrd++;
            end
            if (u_if.patch_valid) begin
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
                if (nval < exp_data.size()) begin
                    check({nm, "_data"}, u_if.patch_data, exp_data[nval]);
                    check({nm, "_last"}, u_if.patch_last, (nval % 16 == 15) ? 32'd1 : 32'd0);
                end else prot_ok = 0;
                got_q.push_back(u_if.patch_data);
                nval++;
                if (nval == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs({nm, "_midrst"});
                    u_if.hold = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (done) begin
                done_cyc = cyc;
                check({nm, "_done_idle"}, {busy, u_if.sftm_start}, 32'd0);
                break;
            end
        end
        if (done_cyc < 0) check({nm, "_done_timeout"}, 32'd0, 32'd1);
        check({nm, "_nsamples"}, nval, exp_data.size());
        check({nm, "_nreads"}, nrd, exp_addr.size());
        check({nm, "_protocol"}, prot_ok, 32'd1);
        check({nm, "_credit"}, credit_ok, 32'd1);
        if (!hold_rand) begin
            check({nm, "_done_cyc"}, done_cyc, (np == 0) ? 1 : 16 * np + 3);
            if (np > 0) begin
                check({nm, "_first_rd"}, first_rd, 32'd1);
                check({nm, "_first_val"}, first_val, 32'd3);
                check({nm, "_contig"}, last_val - first_val + 1, nval);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy || mem_rd_en || u_if.patch_valid || u_if.sftm_start) post_ok = 0;
        end
        check({nm, "_post_idle"}, post_ok, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; conv_mode = 1'b0; fm_base = '0;
        fm_width = '0; fm_height = '0; u_if.hold = 1'b0; key = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // 4x4 conv ramp at 0x100.
        run_pass(1'b1, 16'h0100, 4, 4, 1'b0, 0, "t1");
        check("t1_s0", got_at(0), 32'h0100);
        check("t1_s5", got_at(5), 32'h0105);
`ifdef SFTM_STREAMER_BORDER_CLAMP_EN
        check("t1_p1_c4", got_at(18), 32'h0103);
`else
        check("t1_p1_c4", got_at(18), 32'h0000);
`endif

        // 8x8 deconv, no border elements.
        key = 16'($urandom);
        run_pass(1'b0, 16'($urandom), 8, 8, 1'b0, 0, "t2");

        // 6x6 conv under random hold.
        key = 16'($urandom);
        run_pass(1'b1, 16'($urandom), 6, 6, 1'b1, 0, "t3");

        // Zero width: done only.
        run_pass(1'b1, 16'h0040, 0, 5, 1'b0, 0, "t4");

        // Reset at patch 2 sample 7, then a clean pass.
        key = 16'($urandom);
        run_pass(1'b1, 16'h0300, 6, 6, 1'b0, 40, "t5a");
        run_pass(1'b1, 16'h0300, 6, 6, 1'b0, 0, "t5b");

        // Address wrap at the top of the buffer.
        key = 16'h0;
        run_pass(1'b1, 16'hFFFE, 4, 4, 1'b0, 0, "t6");
        check("t6_s0", got_at(0), 32'hFFFE);
        check("t6_s2", got_at(2), 32'h0000);

        // 3x3 conv: right-border patch.
        run_pass(1'b1, 16'h0200, 3, 3, 1'b0, 0, "t7");
`ifdef SFTM_STREAMER_BORDER_CLAMP_EN
        check("t7_p1_c3", got_at(17), 32'h0202);
`else
        check("t7_p1_c3", got_at(17), 32'h0000);
`endif

        // Random passes.
        for (int n = 0; n < 4; n++) begin
            key = 16'($urandom);
            run_pass(1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(1, 9)),
                     int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)), 0, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
